// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: issues imem requests, advances PC on accept, buffers redirects behind an outstanding delay-slot fetch.
// Latency: one instruction per cycle with imem_ready=1; stall freezes the PC and parks an accepted fetch in HOLD.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        j_req,
  input  logic        jr_req,
  input  logic [31:0] npc_target,
  input  logic [31:0] jr_target,
  output logic [1:0]  npc_sel,
  output logic [31:0] pc_out,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic        redirect_pending,
  output logic        pc_misalign
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_tgt;

  logic        w_sample;
  logic        w_redirect;
  logic [31:0] w_redir_tgt;
  logic        w_advance;
  logic [31:0] w_next_pc;

  // Redirects are only seen once the sequencer is live and the F/D stage is not frozen.
  assign w_sample    = reset && !stall && (r_state != S_BOOT);
  assign w_redirect  = w_sample && (jr_req || j_req || br_taken);
  assign w_redir_tgt = jr_req ? jr_target : npc_target;

  assign w_advance = reset && !stall &&
                     (((r_state == S_FETCH) && imem_ready) || (r_state == S_HOLD));

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (r_pend) begin
      w_next_pc = r_pend_tgt;
    end else if (w_redirect) begin
      w_next_pc = w_redir_tgt;
    end
  end

  assign npc_sel          = br_taken ? 2'd1 : (j_req ? 2'd2 : 2'd0);
  assign pc_out           = r_pc;
  assign imem_req         = (r_state == S_FETCH);
  assign instr_valid      = w_advance;
  assign redirect_pending = r_pend;
  assign pc_misalign      = |r_pc[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: if (imem_ready && stall) r_state <= S_HOLD;
        S_HOLD:  if (!stall) r_state <= S_FETCH;
        default: r_state <= S_BOOT;
      endcase

      // First redirect wins; a second one arriving while buffered is dropped.
      if (w_advance) begin
        r_pc   <= w_next_pc;
        r_pend <= 1'b0;
      end else if (w_redirect && !r_pend) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= w_redir_tgt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        j_req = 1'b0;
  logic        jr_req = 1'b0;
  logic [31:0] npc_target = 32'd0;
  logic [31:0] jr_target = 32'd0;
  logic        imem_ready = 1'b1;
  logic [1:0]  npc_sel;
  logic [31:0] pc_out;
  logic        imem_req;
  logic        instr_valid;
  logic        redirect_pending;
  logic        pc_misalign;

  int total = 0;
  int bad = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .j_req(j_req),
    .jr_req(jr_req), .npc_target(npc_target), .jr_target(jr_target), .npc_sel(npc_sel),
    .pc_out(pc_out), .imem_req(imem_req), .imem_ready(imem_ready), .instr_valid(instr_valid),
    .redirect_pending(redirect_pending), .pc_misalign(pc_misalign)
  );

  always #5 clk = ~clk;

  // Reference model: where the sequencer is (booting / fetching / holding), the PC, and the redirect buffer.
  logic        m_boot, m_hold, m_pend;
  logic [31:0] m_pc, m_pend_tgt;
  logic        m_adv, m_take;
  logic [31:0] m_tgt;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 32'h3000; m_boot = 1'b1; m_hold = 1'b0; m_pend = 1'b0;
    end else begin
      m_adv  = !m_boot && !stall && (m_hold || imem_ready);
      m_take = !m_boot && !stall && (jr_req || j_req || br_taken);
      m_tgt  = jr_req ? jr_target : npc_target;
      if (m_boot) m_boot = 1'b0;
      else if (m_hold) m_hold = stall;
      else if (imem_ready && stall) m_hold = 1'b1;
      if (m_adv) begin
        if (m_pend) begin m_pc = m_pend_tgt; m_pend = 1'b0; end
        else if (m_take) m_pc = m_tgt;
        else m_pc = m_pc + 32'd4;
      end else if (m_take && !m_pend) begin
        m_pend = 1'b1; m_pend_tgt = m_tgt;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (pc_out !== 32'h3000) begin bad++; $display("FAIL reset_pc cyc%0d got=%h exp=3000", k, pc_out); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req cyc%0d got=%b exp=0", k, imem_req); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_iv cyc%0d got=%b exp=0", k, instr_valid); end
      total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL reset_pend cyc%0d got=%b exp=0", k, redirect_pending); end
    end
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL boot_iv got=%b exp=0", instr_valid); end
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (pc_out !== 32'h3000 + 32'(4 * k)) begin bad++; $display("FAIL seq_pc k=%0d got=%h exp=%h", k, pc_out, 32'h3000 + 32'(4 * k)); end
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_iv k=%0d got=%b exp=1", k, instr_valid); end
      step();
    end
  endtask

  task automatic test_branch;
    br_taken = 1'b1; npc_target = 32'h3040;
    #1;
    total++; if (npc_sel !== 2'd1) begin bad++; $display("FAIL br_sel got=%0d exp=1", npc_sel); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL br_iv got=%b exp=1", instr_valid); end
    step();
    br_taken = 1'b0;
    total++; if (pc_out !== 32'h3040) begin bad++; $display("FAIL br_pc got=%h exp=3040", pc_out); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL br_pend got=%b exp=0", redirect_pending); end
  endtask

  task automatic test_jump_pending;
    imem_ready = 1'b0; j_req = 1'b1; npc_target = 32'h3100;
    #1;
    total++; if (npc_sel !== 2'd2) begin bad++; $display("FAIL j_sel got=%0d exp=2", npc_sel); end
    step();
    j_req = 1'b0; npc_target = 32'h0;
    #1;
    total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL j_pend got=%b exp=1", redirect_pending); end
    total++; if (pc_out !== 32'h3040) begin bad++; $display("FAIL j_hold_pc got=%h exp=3040", pc_out); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL j_wait_iv got=%b exp=0", instr_valid); end
    step();
    imem_ready = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL j_slot_iv got=%b exp=1", instr_valid); end
    total++; if (pc_out !== 32'h3040) begin bad++; $display("FAIL j_slot_pc got=%h exp=3040", pc_out); end
    step();
    total++; if (pc_out !== 32'h3100) begin bad++; $display("FAIL j_tgt_pc got=%h exp=3100", pc_out); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL j_clear got=%b exp=0", redirect_pending); end
  endtask

  task automatic test_stall;
    stall = 1'b1; jr_req = 1'b1; jr_target = 32'hDEAD_0000;
    #1;
    total++; if (npc_sel !== 2'd0) begin bad++; $display("FAIL jr_sel got=%0d exp=0", npc_sel); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_iv0 got=%b exp=0", instr_valid); end
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req k=%0d got=%b exp=0", k, imem_req); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL hold_iv k=%0d got=%b exp=0", k, instr_valid); end
      total++; if (pc_out !== 32'h3100) begin bad++; $display("FAIL hold_pc k=%0d got=%h exp=3100", k, pc_out); end
      step();
    end
    stall = 1'b0; jr_req = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL unstall_iv got=%b exp=1", instr_valid); end
    step();
    total++; if (pc_out !== 32'h3104) begin bad++; $display("FAIL unstall_pc got=%h exp=3104", pc_out); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL unstall_pend got=%b exp=0", redirect_pending); end
  endtask

  task automatic test_reset_pending;
    imem_ready = 1'b0; j_req = 1'b1; npc_target = 32'h5000;
    step();
    j_req = 1'b0; npc_target = 32'h0;
    total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL rp_set got=%b exp=1", redirect_pending); end
    reset = 1'b0;
    step();
    reset = 1'b1; imem_ready = 1'b1;
    total++; if (pc_out !== 32'h3000) begin bad++; $display("FAIL rp_pc got=%h exp=3000", pc_out); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL rp_pend got=%b exp=0", redirect_pending); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rp_boot got=%b exp=0", imem_req); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (pc_out === 32'h5000) begin bad++; $display("FAIL rp_stale k=%0d got=%h", k, pc_out); end
    end
    total++; if (pc_out !== 32'h300C) begin bad++; $display("FAIL rp_resume got=%h exp=300c", pc_out); end
  endtask

  task automatic test_wrap;
    br_taken = 1'b1; npc_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    total++; if (pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_tgt got=%h exp=fffffffc", pc_out); end
    step();
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", pc_out); end
    jr_req = 1'b1; j_req = 1'b1; jr_target = 32'h3002; npc_target = 32'h4000;
    step();
    jr_req = 1'b0; j_req = 1'b0;
    total++; if (pc_out !== 32'h3002) begin bad++; $display("FAIL jr_prio got=%h exp=3002", pc_out); end
    total++; if (pc_misalign !== 1'b1) begin bad++; $display("FAIL misalign got=%b exp=1", pc_misalign); end
  endtask

  task automatic test_random;
    logic exp_iv;
    logic [1:0] exp_sel;
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 49) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      br_taken   = ($urandom_range(0, 6) == 0);
      j_req      = ($urandom_range(0, 6) == 0);
      jr_req     = ($urandom_range(0, 6) == 0);
      npc_target = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jr_target  = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      #1;
      exp_iv  = reset && !m_boot && !stall && (m_hold || imem_ready);
      exp_sel = br_taken ? 2'd1 : (j_req ? 2'd2 : 2'd0);
      total++; if (pc_out !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc_out, m_pc); end
      total++; if (imem_req !== (!m_boot && !m_hold)) begin bad++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, imem_req, !m_boot && !m_hold); end
      total++; if (instr_valid !== exp_iv) begin bad++; $display("FAIL rnd_iv n=%0d got=%b exp=%b", n, instr_valid, exp_iv); end
      total++; if (redirect_pending !== m_pend) begin bad++; $display("FAIL rnd_pend n=%0d got=%b exp=%b", n, redirect_pending, m_pend); end
      total++; if (pc_misalign !== (m_pc[1:0] != 2'b00)) begin bad++; $display("FAIL rnd_mis n=%0d got=%b pc=%h", n, pc_misalign, m_pc); end
      total++; if (npc_sel !== exp_sel) begin bad++; $display("FAIL rnd_sel n=%0d got=%0d exp=%0d", n, npc_sel, exp_sel); end
      step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_pending();
    test_stall();
    test_reset_pending();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
